// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute hazard inputs and pipeline controls.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if;
    logic [4:0] ifid_rs_i;
    logic [4:0] ifid_rt_i;
    logic       idex_memread_i;
    logic [4:0] idex_rt_i;
    logic       branch_taken_i;
    logic       mem_busy_i;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       idex_flush_o;
    logic       exmem_flush_o;
    logic [1:0] state_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
        output branch_taken_i, mem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o,
        input  idex_flush_o, exmem_flush_o, state_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
        input  branch_taken_i, mem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o,
        output idex_flush_o, exmem_flush_o, state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard FSM: load-use stall, branch flush, memory-wait freeze.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    state_t     r_ret;
    state_t     w_ret_nxt;
    logic [2:0] r_fcnt;
    logic [2:0] w_fcnt_nxt;

    logic w_lu_hit;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_fl;
    logic w_idex_fl;
    logic w_exmem_fl;

    assign w_lu_hit = hz.idex_memread_i
                   && (hz.idex_rt_i != 5'd0)
                   && ((hz.idex_rt_i == hz.ifid_rs_i)
                    || (hz.idex_rt_i == hz.ifid_rt_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_fcnt_nxt  = r_fcnt;
        w_pc_we     = 1'b1;
        w_ifid_we   = 1'b1;
        w_ifid_fl   = 1'b0;
        w_idex_fl   = 1'b0;
        w_exmem_fl  = 1'b0;

        if (hz.mem_busy_i) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            if (r_state != MEM_WAIT) begin
                w_ret_nxt   = r_state;
                w_state_nxt = MEM_WAIT;
            end
        end else begin
            unique case (r_state)
                MEM_WAIT: begin
                    // Recovery cycle: still frozen, resume next cycle
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_state_nxt = r_ret;
                end
                FLUSH: begin
                    w_ifid_fl = 1'b1;
                    w_idex_fl = 1'b1;
                    if (r_fcnt <= 3'd1) begin
                        w_fcnt_nxt  = 3'd0;
                        w_state_nxt = RUN;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 3'd1;
                    end
                end
                RUN, LU_STALL: begin
                    if (hz.branch_taken_i) begin
                        w_ifid_fl  = 1'b1;
                        w_idex_fl  = 1'b1;
                        w_exmem_fl = 1'b1;
                        if (FLUSH_LEN > 1) begin
                            w_fcnt_nxt  = 3'(FLUSH_LEN - 1);
                            w_state_nxt = FLUSH;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end else if (w_lu_hit && (r_state == RUN)) begin
                        w_pc_we     = 1'b0;
                        w_ifid_we   = 1'b0;
                        w_idex_fl   = 1'b1;
                        w_state_nxt = LU_STALL;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    assign hz.pc_write_o    = w_pc_we    & ~rst_i;
    assign hz.ifid_write_o  = w_ifid_we  & ~rst_i;
    assign hz.ifid_flush_o  = w_ifid_fl  & ~rst_i;
    assign hz.idex_flush_o  = w_idex_fl  & ~rst_i;
    assign hz.exmem_flush_o = w_exmem_fl & ~rst_i;
    assign hz.state_o       = r_state;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_ifid_fl && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
